// File: rtl/wb_port_arbiter.sv
// Register-file write-port owner: merges pipeline writebacks with in-order load responses,
// tracks outstanding load destinations in a tag FIFO and stalls the pipeline on hazards.
module wb_port_arbiter #(
    parameter int LD_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pipe_valid_i,
    output logic        pipe_ready_o,
    input  logic [1:0]  pipe_src_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_alu_i,
    input  logic [31:0] pipe_pc_i,
    input  logic [31:0] pipe_pctarget_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_data_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] busy_o,
    output logic        err_o
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(LD_DEPTH);

    function automatic logic [31:0] pipe_wdata(input logic [1:0]  src,
                                               input logic [31:0] alu,
                                               input logic [31:0] pc,
                                               input logic [31:0] tgt);
        logic [31:0] d;
        case (src)
            2'd0:    d = alu;
            2'd2:    d = pc + 32'd4;
            2'd3:    d = tgt;
            default: d = alu;
        endcase
        return d;
    endfunction

    logic [4:0]    tag_q [LD_DEPTH];
    logic [4:0]    tag_d [LD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          skid_valid_q, skid_valid_d;
    logic [4:0]    skid_addr_q, skid_addr_d;
    logic [31:0]   skid_data_q, skid_data_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          err_q, err_d;
    logic          ld_ready_q;

    logic [31:0]   busy_s;
    logic [PW-1:0] off_s;
    logic          pipe_ready_s;
    logic          ld_fire_s, pipe_fire_s, pipe_wr_s, push_s, pop_s;
    logic [31:0]   pipe_data_s;
    logic [4:0]    head_s;

    // Scoreboard: one bit per destination of every occupied FIFO slot.
    always_comb begin
        busy_s = 32'd0;
        off_s  = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            off_s  = PW'(i) - rd_ptr_q;
            busy_s = busy_s | ((({1'b0, off_s} < count_q)) ? (32'd1 << tag_q[i]) : 32'd0);
        end
        busy_s[0] = 1'b0;
    end

    // Acceptance: a full skid blocks everything; loads need a free tag slot, writes no WAW hazard.
    always_comb begin
        pipe_ready_s = 1'b0;
        if (skid_valid_q) begin
            pipe_ready_s = 1'b0;
        end else begin
            case (pipe_src_i)
                2'd1:    pipe_ready_s = (count_q != FULL_CNT);
                default: pipe_ready_s = (pipe_rd_i == 5'd0) || !busy_s[pipe_rd_i];
            endcase
        end
    end

    // Port arbitration (load > skid > new pipe write) and tag FIFO update.
    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        ld_fire_s   = ld_valid_i & ld_ready_q;
        pipe_fire_s = pipe_valid_i & pipe_ready_s;
        push_s      = pipe_fire_s & (pipe_src_i == 2'd1);
        pipe_wr_s   = pipe_fire_s & (pipe_src_i != 2'd1) & (pipe_rd_i != 5'd0);
        pop_s       = ld_fire_s & (count_q != '0);
        pipe_data_s = pipe_wdata(pipe_src_i, pipe_alu_i, pipe_pc_i, pipe_pctarget_i);
        head_s      = tag_q[rd_ptr_q];
        err_d       = err_q | (ld_fire_s & (count_q == '0));

        if (ld_fire_s) begin
            if (pop_s) begin
                rf_we_d    = (head_s != 5'd0);
                rf_waddr_d = head_s;
                rf_wdata_d = ld_data_i;
            end else begin
                rf_we_d = 1'b0;
            end
            // The port is taken; an accepted pipe write waits one slot in the skid.
            if (pipe_wr_s) begin
                skid_valid_d = 1'b1;
                skid_addr_d  = pipe_rd_i;
                skid_data_d  = pipe_data_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end else if (skid_valid_q) begin
            rf_we_d      = 1'b1;
            rf_waddr_d   = skid_addr_q;
            rf_wdata_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (pipe_wr_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd_i;
            rf_wdata_d = pipe_data_s;
        end else begin
            rf_we_d = 1'b0;
        end

        if (push_s) begin
            tag_d[wr_ptr_q] = pipe_rd_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                tag_q[i] <= 5'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= 5'd0;
            skid_data_q  <= 32'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            err_q        <= err_d;
            ld_ready_q   <= 1'b1;
        end
    end

    assign pipe_ready_o = pipe_ready_s;
    assign ld_ready_o   = ld_ready_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign busy_o       = busy_s;
    assign err_o        = err_q;

endmodule
